state_sequencer: RTL and testbench

- Owns the multicycle CPU state register and steps it FETCH -> EXEC1 -> EXEC2 for each instruction.
- Stalls on memory `waitrequest` and on a busy multiply/divide unit.
- Detects the halt condition (jump to address 0) and drives `active_o`.
- Sits beside the combinational control decoder: its `state_o` feeds the decoder's state input, and the decoder's RAM enables feed back here to qualify stalls.

---
 rtl/state_sequencer_pkg.sv | 13 +
 rtl/state_sequencer_perf_counter.sv | 23 ++
 rtl/state_sequencer.sv | 88 ++++++++
 tb/tb_state_sequencer.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/state_sequencer_pkg.sv
// Shared types for the multicycle CPU sequencer: state encoding and default halt address.
package codes;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        EXEC1 = 2'd1,
        EXEC2 = 2'd2,
        HALT  = 2'd3
    } state_t;

    localparam logic [31:0] HALT_ADDR_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/state_sequencer_perf_counter.sv
// Free-running wrap-around event counter with enable; used for cycle/instruction statistics.
module perf_counter #(
    parameter int WIDTH = 32
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_en,
    output logic [WIDTH-1:0] o_count
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else if (i_en) begin
            r_count <= r_count + WIDTH'(1);
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/state_sequencer.sv
// Multicycle CPU state register FETCH->EXEC1->EXEC2 with memory/multdiv stalls and halt detect.
// Optional performance counters are enabled by defining SEQ_PERF_COUNTERS_EN.
module state_sequencer
    import codes::*;
#(
    parameter logic [31:0] HALT_ADDR = HALT_ADDR_DEFAULT
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        ram_read_en_i,
    input  logic        ram_write_en_i,
    input  logic        ram_waitrequest_i,
    input  logic        multdiv_busy_i,
    input  logic [31:0] pc_next_i,
    output state_t      state_o,
    output logic        stall_o,
    output logic        retire_o,
    output logic        active_o,
    output logic [31:0] cycle_count_o,
    output logic [31:0] instr_count_o
);

    state_t r_state;
    state_t w_state_next;
    logic   r_active;
    logic   w_stall;
    logic   w_retire;

    // NOTE: every output of this block gets a default first so no path can infer a latch.
    always_comb begin
        w_state_next = r_state;
        w_stall      = 1'b0;
        case (r_state)
            FETCH, EXEC1: begin
                w_stall = ram_read_en_i & ram_waitrequest_i;
                if (!w_stall) begin
                    w_state_next = (r_state == FETCH) ? EXEC1 : EXEC2;
                end
            end
            EXEC2: begin
                // A store wait and a busy multdiv overlap into one stall, not two.
                w_stall = (ram_write_en_i & ram_waitrequest_i) | multdiv_busy_i;
                if (!w_stall) begin
                    w_state_next = (pc_next_i == HALT_ADDR) ? HALT : FETCH;
                end
            end
            default: w_state_next = HALT;
        endcase
    end

    assign w_retire = (r_state == EXEC2) & ~w_stall;

    // NOTE: state is updated with non-blocking assignments so all flops sample pre-edge values.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state  <= FETCH;
            r_active <= 1'b1;
        end else begin
            r_state  <= w_state_next;
            r_active <= (w_state_next != HALT);
        end
    end

    assign state_o  = r_state;
    assign stall_o  = w_stall;
    assign retire_o = w_retire;
    assign active_o = r_active;

`ifdef SEQ_PERF_COUNTERS_EN
    perf_counter #(.WIDTH(32)) u_cycle_counter (
        .i_clk   (clk_i),
        .i_rst_n (rst_ni),
        .i_en    (r_state != HALT),
        .o_count (cycle_count_o)
    );

    perf_counter #(.WIDTH(32)) u_instr_counter (
        .i_clk   (clk_i),
        .i_rst_n (rst_ni),
        .i_en    (w_retire),
        .o_count (instr_count_o)
    );
`else
    assign cycle_count_o = 32'd0;
    assign instr_count_o = 32'd0;
`endif

endmodule

// File: tb/tb_state_sequencer.sv
// Self-checking bench for state_sequencer: reset, directed table, multi-cycle corners, random run.
module tb_state_sequencer;
    import codes::*;

    logic        clk;
    logic        rst_ni;
    logic        ram_read_en;
    logic        ram_write_en;
    logic        ram_waitrequest;
    logic        multdiv_busy;
    logic [31:0] pc_next;
    state_t      state_o;
    logic        stall_o;
    logic        retire_o;
    logic        active_o;
    logic [31:0] cycle_count_o;
    logic [31:0] instr_count_o;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: a phase index within the instruction plus a halted flag.
    int          m_phase;
    bit          m_halted;
    logic [31:0] m_cyc;
    logic [31:0] m_ins;

    // Last observation, for the directed sequences.
    int obs_state;
    bit obs_stall;
    bit obs_retire;

    state_sequencer #(.HALT_ADDR(32'h0000_0000)) dut (
        .clk_i             (clk),
        .rst_ni            (rst_ni),
        .ram_read_en_i     (ram_read_en),
        .ram_write_en_i    (ram_write_en),
        .ram_waitrequest_i (ram_waitrequest),
        .multdiv_busy_i    (multdiv_busy),
        .pc_next_i         (pc_next),
        .state_o           (state_o),
        .stall_o           (stall_o),
        .retire_o          (retire_o),
        .active_o          (active_o),
        .cycle_count_o     (cycle_count_o),
        .instr_count_o     (instr_count_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase  = 0;
        m_halted = 0;
        m_cyc    = 32'd0;
        m_ins    = 32'd0;
    endtask

    // One clock cycle: drive inputs just after the edge, compare mid-cycle, advance the model.
    task automatic run_cycle(input bit rd, input bit wr, input bit wt, input bit bz,
                             input logic [31:0] pc);
        bit exp_stall;
        bit exp_retire;
        ram_read_en     = rd;
        ram_write_en    = wr;
        ram_waitrequest = wt;
        multdiv_busy    = bz;
        pc_next         = pc;
        #3;
        if (m_halted)          exp_stall = 0;
        else if (m_phase == 2) exp_stall = (wr && wt) || bz;
        else                   exp_stall = rd && wt;
        exp_retire = !m_halted && (m_phase == 2) && !exp_stall;

        obs_state  = int'(state_o);
        obs_stall  = stall_o;
        obs_retire = retire_o;
        check("state",  32'(obs_state), m_halted ? 32'd3 : 32'(m_phase));
        check("stall",  32'(obs_stall), 32'(exp_stall));
        check("retire", 32'(obs_retire), 32'(exp_retire));
        check("active", 32'(active_o), 32'(!m_halted));
        check("cycle_count", cycle_count_o, m_cyc);
        check("instr_count", instr_count_o, m_ins);

        if (!m_halted) begin
`ifdef SEQ_PERF_COUNTERS_EN
            m_cyc = m_cyc + 32'd1;
            if (exp_retire) m_ins = m_ins + 32'd1;
`endif
            if (!exp_stall) begin
                if (m_phase == 2) begin
                    m_phase = 0;
                    if (pc == 32'h0000_0000) m_halted = 1;
                end else begin
                    m_phase = m_phase + 1;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic reset_pulse(input string tag);
        rst_ni          = 1'b0;
        ram_read_en     = 1'b0;
        ram_write_en    = 1'b0;
        ram_waitrequest = 1'b0;
        multdiv_busy    = 1'b0;
        #1;
        check({tag, "_state"},  32'(state_o), 32'd0);
        check({tag, "_active"}, 32'(active_o), 32'd1);
        check({tag, "_cyc"},    cycle_count_o, 32'd0);
        check({tag, "_ins"},    instr_count_o, 32'd0);
        check({tag, "_stall"},  32'(stall_o), 32'd0);
        check({tag, "_retire"}, 32'(retire_o), 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        rst_ni = 1'b1;
    endtask

    typedef struct {
        bit          rd, wr, wt, bz;
        logic [31:0] pc;
        int          exp_state;
        bit          exp_stall, exp_retire;
    } vec_t;

    vec_t vecs [11];

    initial begin
        int retires, stalls, fetch_cycles, halt_cycles;

        vecs[0]  = '{0, 0, 0, 0, 32'h4, 0, 0, 0};
        vecs[1]  = '{0, 0, 0, 0, 32'h4, 1, 0, 0};
        vecs[2]  = '{0, 0, 0, 0, 32'h4, 2, 0, 1};
        vecs[3]  = '{1, 0, 1, 0, 32'h4, 0, 1, 0};
        vecs[4]  = '{1, 0, 0, 0, 32'h4, 0, 0, 0};
        vecs[5]  = '{1, 0, 1, 0, 32'h4, 1, 1, 0};
        vecs[6]  = '{0, 0, 1, 0, 32'h4, 1, 0, 0};
        vecs[7]  = '{0, 1, 1, 1, 32'h0, 2, 1, 0};
        vecs[8]  = '{0, 1, 1, 0, 32'h0, 2, 1, 0};
        vecs[9]  = '{0, 0, 1, 0, 32'h8, 2, 0, 1};
        vecs[10] = '{0, 0, 1, 0, 32'h4, 0, 0, 0};

        rst_ni          = 1'b0;
        ram_read_en     = 1'b0;
        ram_write_en    = 1'b0;
        ram_waitrequest = 1'b0;
        multdiv_busy    = 1'b0;
        pc_next         = 32'h4;
        model_reset();
        @(posedge clk);
        #1;
        reset_pulse("reset");

        // Plain instructions: three per 9 cycles.
        retires = 0;
        for (int i = 0; i < 9; i++) begin
            run_cycle(0, 0, 0, 0, 32'h4);
            if (obs_retire) retires++;
        end
        check("plain_retires", 32'(retires), 32'd3);
`ifdef SEQ_PERF_COUNTERS_EN
        check("plain_instr_count", instr_count_o, 32'd3);
        check("plain_cycle_count", cycle_count_o, 32'd9);
`else
        check("plain_instr_count", instr_count_o, 32'd0);
        check("plain_cycle_count", cycle_count_o, 32'd0);
`endif

        for (int i = 0; i < 11; i++) begin
            run_cycle(vecs[i].rd, vecs[i].wr, vecs[i].wt, vecs[i].bz, vecs[i].pc);
            check($sformatf("vec%0d_state", i), 32'(obs_state), 32'(vecs[i].exp_state));
            check($sformatf("vec%0d_stall", i), 32'(obs_stall), 32'(vecs[i].exp_stall));
            check($sformatf("vec%0d_retire", i), 32'(obs_retire), 32'(vecs[i].exp_retire));
        end

        // Now in EXEC1; finish the instruction to get back to FETCH.
        run_cycle(0, 0, 0, 0, 32'h4);
        run_cycle(0, 0, 0, 0, 32'h4);

        // FETCH held by four wait cycles.
        fetch_cycles = 0;
        stalls = 0;
        for (int i = 0; i < 5; i++) begin
            run_cycle(1, 0, (i < 4), 0, 32'h4);
            if (obs_state == 0) fetch_cycles++;
            if (obs_stall) stalls++;
        end
        check("fetch_hold_cycles", 32'(fetch_cycles), 32'd5);
        check("fetch_stalls", 32'(stalls), 32'd4);
        check("fetch_then_exec1", 32'(state_o), 32'd1);
        run_cycle(0, 0, 0, 0, 32'h4);

        // EXEC2: busy for 2 cycles, store wait for 3 -> 4 cycles, one retire.
        retires = 0;
        stalls = 0;
        for (int i = 0; i < 4; i++) begin
            run_cycle(0, 1, (i < 3), (i < 2), 32'h4);
            if (obs_retire) retires++;
            if (obs_stall) stalls++;
        end
        check("exec2_retires", 32'(retires), 32'd1);
        check("exec2_stalls", 32'(stalls), 32'd3);
        check("exec2_then_fetch", 32'(state_o), 32'd0);

        // Halt: jump to address 0.
        run_cycle(0, 0, 0, 0, 32'h4);
        run_cycle(0, 0, 0, 0, 32'h4);
        run_cycle(0, 0, 0, 0, 32'h0);
        check("halt_retire", 32'(obs_retire), 32'd1);
        halt_cycles = 0;
        for (int i = 0; i < 12; i++) begin
            run_cycle(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), $urandom);
            if (obs_state == 3 && !obs_stall && !obs_retire) halt_cycles++;
        end
        check("halt_absorbing", 32'(halt_cycles), 32'd12);
        check("halt_active", 32'(active_o), 32'd0);

        reset_pulse("reset_in_halt");

        // Reset asserted mid-EXEC1 while a load stall is pending.
        run_cycle(0, 0, 0, 0, 32'h4);
        ram_read_en     = 1'b1;
        ram_waitrequest = 1'b1;
        #2;
        check("pre_reset_exec1", 32'(state_o), 32'd1);
        reset_pulse("reset_in_exec1");

`ifdef SEQ_PERF_COUNTERS_EN
        run_cycle(0, 0, 0, 0, 32'h4);
        force dut.u_cycle_counter.r_count = 32'hFFFF_FFFF;
        #1;
        release dut.u_cycle_counter.r_count;
        m_cyc = 32'hFFFF_FFFF;
        run_cycle(0, 0, 0, 0, 32'h4);
        check("cycle_wrap", cycle_count_o, 32'd0);
`endif

        // Random stimulus, restarting by reset after a few halted cycles.
        halt_cycles = 0;
        for (int i = 0; i < 600; i++) begin
            if (m_halted && halt_cycles > 4) begin
                reset_pulse("rand_reset");
                halt_cycles = 0;
            end else begin
                if (m_halted) halt_cycles++;
                run_cycle(1'($urandom), 1'($urandom), ($urandom_range(0, 2) == 0),
                          ($urandom_range(0, 3) == 0),
                          ($urandom_range(0, 7) == 0) ? 32'h0 : ($urandom | 32'h1));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
